// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   - ALU-compatible opcodes accepted by the sequencer
//   - FSM state encoding
//   - default operand width and the resulting command latency
//   - small opcode classification helpers
package muldiv_pkg;

  localparam logic [4:0] OP_DIVU  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd15;
  localparam logic [4:0] OP_DIV   = 5'd16;

  localparam int MULDIV_WIDTH = 32;
  // WIDTH iteration cycles plus the fix-up/commit cycle
  localparam int MULDIV_LAT   = MULDIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  function automatic logic op_valid(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: command/result bundle between the execute stage and the
// multiply/divide sequencer.
//   master (execute stage): drives start, op, a, b, flush
//                           observes busy, done, div_by_zero, hi, lo
//   slave  (sequencer)    : the mirror image
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);

  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one combinational iteration step of the sequencer.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in  : current accumulator
//               multiply: {partial product high, remaining multiplier bits}
//               divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd    : multiplicand (multiply) or divisor (divide) magnitude
//   acc_out : accumulator after one step
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right; the carry lands in the MSB.
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);

    // Divide: partial remainder grows by one dividend bit, giving a
    // WIDTH+1 bit trial value. The stored remainder is always below the
    // divisor (or is a dividend prefix when the divisor is zero), so the
    // post-subtract value always fits in WIDTH bits.
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    diff    = shifted[WIDTH-1:0] - opnd;

    if (is_div) begin
      acc_out = {(ge ? diff : shifted[WIDTH-1:0]), acc_in[WIDTH-2:0], ge};
    end else begin
      acc_out = {mul_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide unit owning HI/LO.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave
//             start/op/a/b : command, sampled only while idle
//             flush        : cancel in-flight work (not in the commit cycle)
//             busy         : operation in progress
//             done         : one-cycle pulse after HI/LO commit
//             div_by_zero  : last committed op was a divide by zero
//             hi/lo        : committed result registers
// Build option: MULDIV_SIGNED_EN - when defined, OP_MULT/OP_DIV are
// two's-complement signed; otherwise they behave as OP_MULTU/OP_DIVU and
// the sign fix-up logic is absent (latency is unchanged).
//
// state | meaning
// IDLE  | waiting for a command
// MUL   | shift-add iterations, WIDTH cycles
// DIV   | restoring-divide iterations, WIDTH cycles
// FIX   | sign fix-up and atomic HI/LO commit, one cycle
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input logic    clk,
  input logic    rst_n,
  muldiv_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               op_div;

  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               cmd_div;
  logic [WIDTH-1:0]   ld_a;
  logic [WIDTH-1:0]   ld_b;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dz;

`ifdef MULDIV_SIGNED_EN
  logic               neg_main;
  logic               neg_rem;
  logic               cmd_signed;
`endif

  assign cmd_div = op_is_div(bus.op);
  assign accept  = (state == IDLE) && bus.start && !bus.flush && op_valid(bus.op);

  // Operand magnitudes; unsigned ops pass through untouched.
  always_comb begin
    ld_a = bus.a;
    ld_b = bus.b;
`ifdef MULDIV_SIGNED_EN
    if (cmd_signed) begin
      if (bus.a[WIDTH-1]) ld_a = -bus.a;
      if (bus.b[WIDTH-1]) ld_b = -bus.b;
    end
`endif
  end

`ifdef MULDIV_SIGNED_EN
  assign cmd_signed = op_is_signed(bus.op);
`endif

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .is_div  (state == DIV),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_step)
  );

  // Commit values presented during FIX.
  always_comb begin
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    res_dz = op_div && (opnd == '0);
`ifdef MULDIV_SIGNED_EN
    if (op_div) begin
      if (neg_main) res_lo = -acc[WIDTH-1:0];
      if (neg_rem)  res_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (neg_main) begin
      {res_hi, res_lo} = -acc;
    end
`endif
    // Divide by zero: the remainder already equals the original dividend
    // (after sign restore); only the quotient is forced.
    if (res_dz) res_lo = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of the low half.
            acc    <= {{WIDTH{1'b0}}, (cmd_div ? ld_a : ld_b)};
            opnd   <= cmd_div ? ld_b : ld_a;
            op_div <= cmd_div;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= cmd_div ? DIV : MUL;
`ifdef MULDIV_SIGNED_EN
            neg_main <= cmd_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem  <= cmd_signed && cmd_div && bus.a[WIDTH-1];
`endif
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          dz_q   <= res_dz;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dz = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic straight from the operation definitions.
  function automatic void model(input logic [4:0] op_i, input logic [W-1:0] a_i,
                                input logic [W-1:0] b_i, output logic [W-1:0] ehi,
                                output logic [W-1:0] elo, output logic edz);
    bit          sgn;
    longint      sa, sb, sq, sr;
    logic [63:0] p, tq, tr;
`ifdef MULDIV_SIGNED_EN
    sgn = op_is_signed(op_i);
`else
    sgn = 1'b0;
`endif
    sa = $signed(a_i);
    sb = $signed(b_i);
    edz = 1'b0;
    if (op_is_div(op_i)) begin
      if (b_i == 0) begin
        ehi = a_i;
        elo = '1;
        edz = 1'b1;
      end else if (sgn) begin
        sq  = sa / sb;
        sr  = sa % sb;
        tq  = sq;
        tr  = sr;
        elo = tq[W-1:0];
        ehi = tr[W-1:0];
      end else begin
        elo = a_i / b_i;
        ehi = a_i % b_i;
      end
    end else begin
      if (sgn) p = sa * sb;
      else     p = {32'b0, a_i} * {32'b0, b_i};
      ehi = p[63:32];
      elo = p[31:0];
    end
  endfunction

  // Called at a negedge with the DUT idle. ign_at / flush_at are negedge
  // indices after acceptance at which an extra start or a flush is driven
  // (-1 = none).
  task automatic run_op(input logic [4:0] op_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input int ign_at, input int flush_at);
    logic [W-1:0] ehi, elo;
    logic         edz;
    int           lat, bcnt, quiet;
    bit           cancelled;
    model(op_i, a_i, b_i, ehi, elo, edz);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(negedge clk);
    bus.start = 1'b0;
    bcnt      = int'(bus.busy);
    lat       = 0;
    cancelled = 1'b0;
    for (int k = 1; k <= LAT + 7; k++) begin
      if (k - 1 == ign_at) begin
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (k - 1 == flush_at) bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (k - 1 == flush_at && flush_at < LAT - 1) begin
        cancelled = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    if (cancelled) begin
      chk("flush_busy", bus.busy, 0);
      chk("flush_done", bus.done, 0);
      chk("flush_hi", bus.hi, last_hi);
      chk("flush_lo", bus.lo, last_lo);
      chk("flush_dz", bus.div_by_zero, last_dz);
      quiet = 0;
      repeat (LAT + 3) begin
        @(negedge clk);
        if (bus.busy || bus.done) quiet++;
      end
      chk("flush_quiet", quiet, 0);
    end else begin
      chk("latency", lat, LAT);
      chk("busy_cycles", bcnt, LAT);
      chk("hi", bus.hi, ehi);
      chk("lo", bus.lo, elo);
      chk("div_by_zero", bus.div_by_zero, edz);
      last_hi = ehi;
      last_lo = elo;
      last_dz = edz;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [4];
  logic [4:0] rop;
  logic [W-1:0] ra, rb;
  int ign, fl;

  initial begin
    ops = '{OP_DIVU, OP_MULTU, OP_MULT, OP_DIV};
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_MULTU, 32'd12, 32'd4, -1, -1);
    chk("mul12x4_hi", bus.hi, 32'd0);
    chk("mul12x4_lo", bus.lo, 32'd48);
    @(negedge clk);
    chk("done_pulse_len", bus.done, 0);

    run_op(OP_DIVU, 32'd13, 32'd4, -1, -1);
    chk("div13_4_hi", bus.hi, 32'd1);
    chk("div13_4_lo", bus.lo, 32'd3);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    chk("mulmax_hi", bus.hi, 32'hFFFF_FFFE);
    chk("mulmax_lo", bus.lo, 32'h0000_0001);
    // issued in the done cycle
    run_op(OP_DIVU, 32'd5, 32'd0, -1, -1);
    chk("dz_hi", bus.hi, 32'd5);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("dz_flag", bus.div_by_zero, 1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
`ifdef MULDIV_SIGNED_EN
    chk("sdiv_lo", bus.lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", bus.hi, 32'hFFFF_FFFF);
`else
    chk("sdiv_lo", bus.lo, 32'h7FFF_FFFC);
    chk("sdiv_hi", bus.hi, 32'd1);
`endif
    chk("sdiv_dz", bus.div_by_zero, 0);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, -1, -1);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1);

    // invalid opcode is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 5'd3;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("badop_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    chk("badop_done", bus.done, 0);
    chk("badop_lo", bus.lo, last_lo);

    // flush wins over start in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULTU;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", bus.busy, 0);

    // commit hi=0 lo=48, then ignored start at 5 and flush at 10
    run_op(OP_MULTU, 32'd12, 32'd4, -1, -1);
    run_op(OP_MULTU, 32'd1234, 32'd5678, 5, 10);
    chk("after_flush_lo", bus.lo, 32'd48);

    // flush during the commit cycle has no effect
    run_op(OP_DIVU, 32'd1000, 32'd7, -1, LAT - 1);

    for (int i = 0; i < 50; i++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = pick();
      rb  = pick();
      ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
      fl  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
      run_op(rop, ra, rb, ign, fl);
    end

    // asynchronous reset mid-operation
    run_op(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5677, -1, -1);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd77;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_pre_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_dz", bus.div_by_zero, 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    last_hi = '0;
    last_lo = '0;
    last_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'd77, 32'd3, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
